// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//
// Record/playback controller for the note RAM (2**ADDR_W words of NOTE_W bits).
// It generates the tempo beat and drives the RAM address, write enable and
// write data. While recording, it OR-accumulates the live one-hot note words
// seen during each beat and writes one word per beat. While playing, it
// replays the stored words, one per beat.
//
// Optional feature (compile-time macro):
//   LOOP_PLAYBACK_EN  - when defined, playback wraps to word 0 after the last
//                       recorded word and repeats until stop. When undefined,
//                       playback returns to IDLE at the end of the song.
//
// Parameters:
//   ADDR_W       RAM address width (depth = 2**ADDR_W)
//   NOTE_W       note word width
//   BASE_PERIOD  beat period in clk cycles at tempo_sel_i = 0
//   STEP_PERIOD  period reduction per tempo_sel_i step
//
// Ports:
//   clk            system clock
//   resetn         synchronous active-low reset
//   start_rec_i    pulse: begin recording (honoured only in IDLE)
//   start_play_i   pulse: begin playback (honoured only in IDLE, rec_len != 0)
//   stop_i         abort current recording/playback
//   tempo_sel_i    tempo select, sampled whenever the beat counter is reloaded
//   note_in_i      live note word
//   ram_q_i        RAM read data (one cycle after ram_addr_o)
//   ram_addr_o     RAM address
//   ram_wdata_o    RAM write data
//   ram_wren_o     RAM write enable, one pulse per recorded beat
//   note_out_o     note being played, 0 when not playing
//   note_valid_o   pulse when note_out_o updates
//   beat_o         pulse at each beat tick while busy
//   busy_o         1 while recording or playing
//   state_o        0 = IDLE, 1 = REC, 2 = PLAY
//   rec_len_o      number of valid recorded words (0 .. 2**ADDR_W)
// -----------------------------------------------------------------------------
module note_sequencer #(
    parameter int ADDR_W      = 6,
    parameter int NOTE_W      = 32,
    parameter int BASE_PERIOD = 75000000,
    parameter int STEP_PERIOD = 8000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_rec_i,
    input  logic              start_play_i,
    input  logic              stop_i,
    input  logic [2:0]        tempo_sel_i,
    input  logic [NOTE_W-1:0] note_in_i,
    input  logic [NOTE_W-1:0] ram_q_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [NOTE_W-1:0] ram_wdata_o,
    output logic              ram_wren_o,
    output logic [NOTE_W-1:0] note_out_o,
    output logic              note_valid_o,
    output logic              beat_o,
    output logic              busy_o,
    output logic [1:0]        state_o,
    output logic [ADDR_W:0]   rec_len_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(BASE_PERIOD + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    // Reload value (period - 1) for each tempo setting, fixed at elaboration.
    logic [CNT_W-1:0] reload_lut [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_reload
        assign reload_lut[gi] = CNT_W'(BASE_PERIOD - 1 - gi * STEP_PERIOD);
    end

    // Registered state and outputs
    state_t            state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [ADDR_W:0]   wr_ptr_q,     wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q,     rd_ptr_d;
    logic [ADDR_W:0]   rec_len_q,    rec_len_d;
    logic [NOTE_W-1:0] acc_q,        acc_d;
    logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
    logic [NOTE_W-1:0] ram_wdata_q,  ram_wdata_d;
    logic              ram_wren_q,   ram_wren_d;
    logic [NOTE_W-1:0] note_out_q,   note_out_d;
    logic              note_valid_q, note_valid_d;
    logic              beat_q,       beat_d;
    logic              busy_q,       busy_d;

    logic              tick;
    logic [CNT_W-1:0]  reload_val;
    logic [ADDR_W-1:0] rd_addr_next;

    assign tick         = (cnt_q == '0);
    assign reload_val   = reload_lut[tempo_sel_i];
    // Address of the word following the one being emitted (prefetch).
    assign rd_addr_next = rd_ptr_q[ADDR_W-1:0] + ADDR_W'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rec_len_d    = rec_len_q;
        acc_d        = acc_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_wren_d   = 1'b0;
        note_out_d   = note_out_q;
        note_valid_d = 1'b0;
        beat_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                acc_d      = '0;
                ram_addr_d = '0;
                note_out_d = '0;
                // Recording takes priority when both starts arrive together.
                if (start_rec_i) begin
                    state_d   = ST_REC;
                    cnt_d     = reload_val;
                    wr_ptr_d  = '0;
                    rec_len_d = '0;
                end else if (start_play_i && (rec_len_q != '0)) begin
                    state_d  = ST_PLAY;
                    cnt_d    = reload_val;
                    rd_ptr_d = '0;
                end
            end

            ST_REC: begin
                if (tick) begin
                    // The note seen on the tick cycle belongs to this beat.
                    ram_wren_d  = 1'b1;
                    ram_addr_d  = wr_ptr_q[ADDR_W-1:0];
                    ram_wdata_d = acc_q | note_in_i;
                    acc_d       = '0;
                    wr_ptr_d    = wr_ptr_q + (ADDR_W+1)'(1);
                    rec_len_d   = wr_ptr_q + (ADDR_W+1)'(1);
                    beat_d      = 1'b1;
                    cnt_d       = reload_val;
                    // A stop on the tick still keeps the completed beat.
                    // The write keeps its address for this cycle; ram_addr
                    // returns to 0 on the following cycle in IDLE.
                    if (stop_i || (wr_ptr_q == (ADDR_W+1)'(DEPTH - 1))) begin
                        state_d = ST_IDLE;
                    end
                end else if (stop_i) begin
                    // Partial beat is discarded.
                    state_d    = ST_IDLE;
                    acc_d      = '0;
                    ram_addr_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    acc_d = acc_q | note_in_i;
                end
            end

            ST_PLAY: begin
                ram_addr_d = rd_ptr_q[ADDR_W-1:0];
                if (stop_i) begin
                    state_d    = ST_IDLE;
                    note_out_d = '0;
                    ram_addr_d = '0;
                    beat_d     = tick;
                end else if (tick) begin
                    beat_d = 1'b1;
                    cnt_d  = reload_val;
                    if (rd_ptr_q == rec_len_q) begin
                        note_out_d = '0;
                        ram_addr_d = '0;
`ifdef LOOP_PLAYBACK_EN
                        // Word 0 is prefetched now and emitted on the next tick.
                        rd_ptr_d = '0;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        note_out_d   = ram_q_i;
                        note_valid_d = 1'b1;
                        rd_ptr_d     = rd_ptr_q + (ADDR_W+1)'(1);
                        ram_addr_d   = rd_addr_next;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d    = ST_IDLE;
                cnt_d      = '0;
                acc_d      = '0;
                ram_addr_d = '0;
                note_out_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rec_len_q    <= '0;
            acc_q        <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_wren_q   <= 1'b0;
            note_out_q   <= '0;
            note_valid_q <= 1'b0;
            beat_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rec_len_q    <= rec_len_d;
            acc_q        <= acc_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_wren_q   <= ram_wren_d;
            note_out_q   <= note_out_d;
            note_valid_q <= note_valid_d;
            beat_q       <= beat_d;
            busy_q       <= busy_d;
        end
    end

    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;
    assign ram_wren_o   = ram_wren_q;
    assign note_out_o   = note_out_q;
    assign note_valid_o = note_valid_q;
    assign beat_o       = beat_q;
    assign busy_o       = busy_q;
    assign state_o      = state_q;
    assign rec_len_o    = rec_len_q;

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
//
// Bench for note_sequencer with BASE_PERIOD=10, STEP_PERIOD=1 (beat period is
// 10 - tempo_sel cycles). A small synchronous-read RAM sits on the RAM port.
// The expected song is derived from the beat rules: each beat's word is the OR
// of every note_in value driven during that beat window.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

    localparam int ADDR_W = 6;
    localparam int NOTE_W = 32;
    localparam int BASE   = 10;
    localparam int STEP   = 1;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start_rec = 1'b0;
    logic              start_play = 1'b0;
    logic              stop = 1'b0;
    logic [2:0]        tempo_sel = 3'd0;
    logic [NOTE_W-1:0] note_in = '0;
    logic [NOTE_W-1:0] ram_q;
    logic [ADDR_W-1:0] ram_addr;
    logic [NOTE_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [NOTE_W-1:0] note_out;
    logic              note_valid;
    logic              beat;
    logic              busy;
    logic [1:0]        state;
    logic [ADDR_W:0]   rec_len;

    int total = 0;
    int bad   = 0;
    logic [NOTE_W-1:0] song [$];
    int exp_len = 0;

    note_sequencer #(
        .ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .BASE_PERIOD(BASE), .STEP_PERIOD(STEP)
    ) dut (
        .clk(clk), .resetn(resetn),
        .start_rec_i(start_rec), .start_play_i(start_play), .stop_i(stop),
        .tempo_sel_i(tempo_sel), .note_in_i(note_in), .ram_q_i(ram_q),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wren_o(ram_wren),
        .note_out_o(note_out), .note_valid_o(note_valid), .beat_o(beat),
        .busy_o(busy), .state_o(state), .rec_len_o(rec_len)
    );

    always #5 clk = ~clk;

    logic [NOTE_W-1:0] mem [1 << ADDR_W];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [NOTE_W-1:0] rand_note();
        logic [NOTE_W-1:0] one = 32'h1;
        if ($urandom_range(0, 3) == 0) return '0;
        return one << $urandom_range(0, 31);
    endfunction

    task automatic test_reset();
        logic [NOTE_W-1:0] nv;
        resetn = 1'b0;
        step(); step();
        total++;
        if ({state, busy, beat, ram_wren, note_valid, note_out, ram_addr, ram_wdata, rec_len} !== '0) begin
            bad++;
            $display("FAIL reset_init: state=%0d busy=%0d rec_len=%0d note_out=%h addr=%0d required all zero",
                     state, busy, rec_len, note_out, ram_addr);
        end
        resetn = 1'b1;
        step();
        tempo_sel = 3'd0;
        start_rec = 1'b1;
        step();
        start_rec = 1'b0;
        repeat (23) begin
            nv = rand_note();
            note_in = nv;
            step();
        end
        total++;
        if (rec_len !== 7'd2) begin
            bad++;
            $display("FAIL reset_pre_len: rec_len=%0d required 2", rec_len);
        end
        resetn = 1'b0;
        step();
        total++;
        if ({state, busy, beat, ram_wren, note_valid, note_out, ram_addr, ram_wdata, rec_len} !== '0) begin
            bad++;
            $display("FAIL reset_mid_rec: state=%0d busy=%0d rec_len=%0d wren=%0d addr=%0d required all zero",
                     state, busy, rec_len, ram_wren, ram_addr);
        end
        resetn = 1'b1;
        note_in = '0;
        step();
        exp_len = 0;
        song.delete();
        $display("test_reset complete");
    endtask

    task automatic test_both_starts();
        start_rec = 1'b1;
        start_play = 1'b1;
        step();
        start_rec = 1'b0;
        start_play = 1'b0;
        total++;
        if (state !== 2'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL both_starts: state=%0d busy=%0d required state=1 busy=1", state, busy);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++;
        if (state !== 2'd0 || rec_len !== 7'd0 || ram_wren !== 1'b0) begin
            bad++;
            $display("FAIL both_starts_stop: state=%0d rec_len=%0d wren=%0d required 0/0/0", state, rec_len, ram_wren);
        end
        exp_len = 0;
        song.delete();
        $display("test_both_starts complete");
    endtask

    task automatic test_play_empty();
        start_play = 1'b1;
        step();
        start_play = 1'b0;
        total++;
        if (state !== 2'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL play_empty: state=%0d busy=%0d required 0/0", state, busy);
        end
        step();
        $display("test_play_empty complete");
    endtask

    task automatic test_record(input int t, input int nb);
        int p = BASE - t * STEP;
        int extra;
        logic [NOTE_W-1:0] acc = '0;
        logic [NOTE_W-1:0] nv;
        tempo_sel = 3'(t);
        start_rec = 1'b1;
        note_in = rand_note();
        step();
        start_rec = 1'b0;
        total++;
        if (state !== 2'd1 || rec_len !== 7'd0) begin
            bad++;
            $display("FAIL rec_enter: state=%0d rec_len=%0d required 1/0", state, rec_len);
        end
        song.delete();
        for (int c = 1; c <= nb * p; c++) begin
            nv = rand_note();
            note_in = nv;
            acc = acc | nv;
            step();
            total++;
            if (c % p == 0) begin
                if (ram_wren !== 1'b1 || ram_addr !== 6'(c / p - 1) || ram_wdata !== acc ||
                    rec_len !== 7'(c / p) || beat !== 1'b1) begin
                    bad++;
                    $display("FAIL rec_write: cyc=%0d wren=%0d addr=%0d data=%h len=%0d beat=%0d required 1/%0d/%h/%0d/1",
                             c, ram_wren, ram_addr, ram_wdata, rec_len, beat, c / p - 1, acc, c / p);
                end
                song.push_back(acc);
                acc = '0;
            end else if (ram_wren !== 1'b0 || beat !== 1'b0) begin
                bad++;
                $display("FAIL rec_idle_cycle: cyc=%0d wren=%0d beat=%0d required 0/0", c, ram_wren, beat);
            end
        end
        extra = $urandom_range(0, p - 2);
        repeat (extra) begin
            note_in = rand_note();
            step();
            total++;
            if (ram_wren !== 1'b0) begin
                bad++;
                $display("FAIL rec_partial: wren=%0d required 0", ram_wren);
            end
        end
        stop = 1'b1;
        note_in = rand_note();
        step();
        stop = 1'b0;
        note_in = '0;
        total++;
        if (state !== 2'd0 || busy !== 1'b0 || ram_wren !== 1'b0 || rec_len !== 7'(nb)) begin
            bad++;
            $display("FAIL rec_stop: state=%0d busy=%0d wren=%0d len=%0d required 0/0/0/%0d",
                     state, busy, ram_wren, rec_len, nb);
        end
        step();
        total++;
        if (ram_addr !== 6'd0 || note_out !== '0) begin
            bad++;
            $display("FAIL rec_idle: addr=%0d note_out=%h required 0/0", ram_addr, note_out);
        end
        exp_len = nb;
        $display("test_record tempo=%0d beats=%0d complete", t, nb);
    endtask

    task automatic test_play(input int t);
        int p = BASE - t * STEP;
        int nt;
        int k;
        logic [NOTE_W-1:0] exp_out = '0;
`ifdef LOOP_PLAYBACK_EN
        nt = exp_len + 2;
`else
        nt = exp_len + 1;
`endif
        tempo_sel = 3'(t);
        start_play = 1'b1;
        step();
        start_play = 1'b0;
        total++;
        if (state !== 2'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL play_enter: state=%0d busy=%0d required 2/1", state, busy);
        end
        for (int c = 1; c <= nt * p; c++) begin
            step();
            k = c / p;
            total++;
            if (c % p != 0) begin
                if (note_valid !== 1'b0 || note_out !== exp_out) begin
                    bad++;
                    $display("FAIL play_hold: cyc=%0d valid=%0d note_out=%h required 0/%h", c, note_valid, note_out, exp_out);
                end
            end else if (k <= exp_len) begin
                exp_out = song[k - 1];
                if (note_valid !== 1'b1 || note_out !== exp_out || beat !== 1'b1) begin
                    bad++;
                    $display("FAIL play_note: beat=%0d valid=%0d note_out=%h required 1/%h", k, note_valid, note_out, exp_out);
                end
            end else if (k == exp_len + 1) begin
                exp_out = '0;
`ifdef LOOP_PLAYBACK_EN
                if (note_valid !== 1'b0 || note_out !== '0 || beat !== 1'b1 || state !== 2'd2) begin
`else
                if (note_valid !== 1'b0 || note_out !== '0 || beat !== 1'b1 || state !== 2'd0 || busy !== 1'b0) begin
`endif
                    bad++;
                    $display("FAIL play_end: valid=%0d note_out=%h beat=%0d state=%0d", note_valid, note_out, beat, state);
                end
            end else begin
                exp_out = song[0];
                if (note_valid !== 1'b1 || note_out !== exp_out) begin
                    bad++;
                    $display("FAIL play_wrap: valid=%0d note_out=%h required 1/%h", note_valid, note_out, exp_out);
                end
            end
        end
`ifdef LOOP_PLAYBACK_EN
        stop = 1'b1;
        step();
        stop = 1'b0;
`endif
        total++;
        if (state !== 2'd0 || note_out !== '0 || rec_len !== 7'(exp_len)) begin
            bad++;
            $display("FAIL play_exit: state=%0d note_out=%h len=%0d required 0/0/%0d", state, note_out, rec_len, exp_len);
        end
        step();
        $display("test_play tempo=%0d len=%0d complete", t, exp_len);
    endtask

    task automatic test_play_stop(input int t);
        int p = BASE - t * STEP;
        tempo_sel = 3'(t);
        start_play = 1'b1;
        step();
        start_play = 1'b0;
        repeat (p) step();
        total++;
        if (note_valid !== 1'b1 || note_out !== song[0]) begin
            bad++;
            $display("FAIL pstop_first: valid=%0d note_out=%h required 1/%h", note_valid, note_out, song[0]);
        end
        repeat ($urandom_range(0, p - 2)) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++;
        if (state !== 2'd0 || note_out !== '0 || note_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL pstop_mid: state=%0d note_out=%h valid=%0d busy=%0d required 0/0/0/0",
                     state, note_out, note_valid, busy);
        end
        step();
        start_play = 1'b1;
        step();
        start_play = 1'b0;
        repeat (p - 1) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        total++;
        if (state !== 2'd0 || note_out !== '0 || note_valid !== 1'b0) begin
            bad++;
            $display("FAIL pstop_tick: state=%0d note_out=%h valid=%0d required 0/0/0", state, note_out, note_valid);
        end
        step();
        $display("test_play_stop tempo=%0d complete", t);
    endtask

    task automatic test_stop_on_tick();
        int p = BASE - 3 * STEP;
        logic [NOTE_W-1:0] acc = '0;
        logic [NOTE_W-1:0] nv;
        tempo_sel = 3'd3;
        start_rec = 1'b1;
        step();
        start_rec = 1'b0;
        song.delete();
        for (int c = 1; c <= 2 * p; c++) begin
            nv = rand_note();
            note_in = nv;
            acc = acc | nv;
            stop = (c == 2 * p);
            step();
            total++;
            if (ram_wren !== (c % p == 0)) begin
                bad++;
                $display("FAIL tick7_spacing: cyc=%0d wren=%0d required %0d", c, ram_wren, (c % p == 0));
            end
            if (c % p == 0) begin
                song.push_back(acc);
                acc = '0;
            end
        end
        stop = 1'b0;
        note_in = '0;
        total++;
        if (state !== 2'd0 || rec_len !== 7'd2 || ram_addr !== 6'd1 || ram_wdata !== song[1]) begin
            bad++;
            $display("FAIL stop_on_tick: state=%0d len=%0d addr=%0d data=%h required 0/2/1/%h",
                     state, rec_len, ram_addr, ram_wdata, song[1]);
        end
        exp_len = 2;
        step();
        $display("test_stop_on_tick complete");
    endtask

    task automatic test_full();
        int p = BASE - 7 * STEP;
        int cnt = 0;
        logic [NOTE_W-1:0] acc = '0;
        logic [NOTE_W-1:0] nv;
        logic exp_wren;
        tempo_sel = 3'd7;
        start_rec = 1'b1;
        step();
        start_rec = 1'b0;
        song.delete();
        for (int c = 1; c <= 66 * p; c++) begin
            nv = rand_note();
            note_in = nv;
            acc = acc | nv;
            step();
            exp_wren = (c % p == 0) && (c / p <= 64);
            total++;
            if (ram_wren !== exp_wren) begin
                bad++;
                $display("FAIL full_wren: cyc=%0d wren=%0d required %0d", c, ram_wren, exp_wren);
            end
            if (exp_wren) begin
                total++;
                if (ram_addr !== 6'(cnt) || ram_wdata !== acc) begin
                    bad++;
                    $display("FAIL full_write: addr=%0d data=%h required %0d/%h", ram_addr, ram_wdata, cnt, acc);
                end
                song.push_back(acc);
                acc = '0;
                cnt++;
            end
            if (c == 64 * p) begin
                total++;
                if (state !== 2'd0 || rec_len !== 7'd64) begin
                    bad++;
                    $display("FAIL full_end: state=%0d len=%0d required 0/64", state, rec_len);
                end
            end
        end
        note_in = '0;
        exp_len = 64;
        $display("test_full writes=%0d complete", cnt);
    endtask

    task automatic test_back_to_back();
        int t;
        int nb;
        for (int r = 0; r < 3; r++) begin
            t = $urandom_range(0, 7);
            nb = $urandom_range(1, 6);
            test_record(t, nb);
            test_play($urandom_range(0, 7));
        end
        $display("test_back_to_back complete");
    endtask

    initial begin
        test_reset();
        test_both_starts();
        test_play_empty();
        test_record(0, 3);
        test_play(0);
        test_play_stop(2);
        test_stop_on_tick();
        test_play(3);
        test_back_to_back();
        test_full();
        test_play(7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
